// File: rtl/key_pkg.sv
// Shared definitions for the key event front end: channel FSM encoding,
// board key indices and the channel counter sizing rule.
package key_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_DB   = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    typedef enum logic [1:0] {
        IDLE       = ST_IDLE,
        PRESS_DB   = ST_PRESS_DB,
        HELD       = ST_HELD,
        RELEASE_DB = ST_RELEASE_DB
    } key_state_t;

    localparam int KEY_LEFT    = 0;
    localparam int KEY_RIGHT   = 1;
    localparam int KEY_UP      = 2;
    localparam int KEY_DOWN    = 3;
    localparam int KEY_CONFIRM = 4;
    localparam int KEY_QUIT    = 5;

    function automatic int cnt_width(input int hold_cyc, input int debounce_cyc);
        return $clog2((hold_cyc > debounce_cyc) ? hold_cyc : debounce_cyc) + 1;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-FF synchroniser, debounce/hold FSM sharing a single counter.
//   state      | meaning
//   IDLE       | key released and stable
//   PRESS_DB   | synced pressed, counting toward accepted press
//   HELD       | press accepted, counting toward next repeat
//   RELEASE_DB | synced released, counting toward accepted release
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int REPEAT_CYC   = 5_000_000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic press_set,
    output logic release_set,
    output logic repeat_set
);

    localparam int CW = cnt_width(HOLD_CYC, DEBOUNCE_CYC);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] RELOAD    = CW'(HOLD_CYC - REPEAT_CYC);

    logic [1:0]    sync_q;
    logic          synced;
    key_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_nxt;

    // Reset value is the raw "not pressed" level, so synced starts at 0.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) sync_q <= {2{ACTIVE_LOW}};
        else        sync_q <= {sync_q[0], key_raw};
    end

    assign synced = sync_q[1] ^ ACTIVE_LOW;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = key_level;
        press_set   = 1'b0;
        release_set = 1'b0;
        repeat_set  = 1'b0;
        case (state)
            IDLE: begin
                if (synced) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (!synced) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HELD: begin
                // A falling synced wins over a due repeat.
                if (!synced) begin
                    state_nxt = RELEASE_DB;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    repeat_set = 1'b1;
                    cnt_nxt    = RELOAD;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RELEASE_DB: begin
                if (synced) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    level_nxt   = 1'b0;
                    release_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            key_level     <= level_nxt;
            press_pulse   <= press_set;
            release_pulse <= release_set;
            repeat_pulse  <= repeat_set;
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// N independent key channels plus registered nav_pulse and any_event,
// built from the channels' next-cycle pulse terms so they align with them.
module key_event_gen
    import key_pkg::*;
#(
    parameter int N_KEYS       = 8,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int REPEAT_CYC   = 5_000_000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic [N_KEYS-1:0] nav_pulse,
    output logic              any_event
);

    logic [N_KEYS-1:0] press_set, release_set, repeat_set;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .HOLD_CYC     (HOLD_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk_50M       (clk_50M),
            .rst_n         (rst_n),
            .key_raw       (key_in[i]),
            .key_level     (key_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i]),
            .press_set     (press_set[i]),
            .release_set   (release_set[i]),
            .repeat_set    (repeat_set[i])
        );
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            nav_pulse <= '0;
            any_event <= 1'b0;
        end else begin
            nav_pulse <= release_set | repeat_set;
            any_event <= |(press_set | release_set);
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed + random bench for key_event_gen, compared every cycle against
// a run-length reference model of the debounce/hold rules.
module tb_key_event_gen;
    import key_pkg::*;

    localparam int NK   = 8;
    localparam int DB   = 8;
    localparam int HOLD = 40;
    localparam int REP  = 10;

    logic          clk_50M = 1'b0;
    logic          rst_n   = 1'b0;
    logic [NK-1:0] key_in  = '1;
    logic [NK-1:0] key_level, press_pulse, release_pulse, repeat_pulse, nav_pulse;
    logic          any_event;

    always #10 clk_50M = ~clk_50M;

    key_event_gen #(
        .N_KEYS       (NK),
        .DEBOUNCE_CYC (DB),
        .HOLD_CYC     (HOLD),
        .REPEAT_CYC   (REP),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk_50M       (clk_50M),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse),
        .nav_pulse     (nav_pulse),
        .any_event     (any_event)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference model state
    logic [NK-1:0] m_s1 = '0, m_s2 = '0;
    logic [NK-1:0] m_level = '0, m_press = '0, m_rel = '0, m_rep = '0, m_nav = '0;
    logic          m_any = 1'b0;
    int one_run[NK], zero_run[NK], hold_t[NK];

    // DUT event counters over a window
    int d_press[NK], d_rel[NK], d_rep[NK], d_nav[NK];
    int d_any = 0;

    task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_cnt(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clr_counts();
        for (int k = 0; k < NK; k++) begin
            d_press[k] = 0; d_rel[k] = 0; d_rep[k] = 0; d_nav[k] = 0;
        end
        d_any = 0;
    endtask

    task automatic model_edge();
        logic [NK-1:0] syn;
        m_press = '0; m_rel = '0; m_rep = '0;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_level = '0;
            for (int k = 0; k < NK; k++) begin
                one_run[k] = 0; zero_run[k] = 0; hold_t[k] = 0;
            end
        end else begin
            syn  = m_s2;
            m_s2 = m_s1;
            m_s1 = ~key_in;
            for (int k = 0; k < NK; k++) begin
                if (!m_level[k]) begin
                    if (syn[k]) begin
                        one_run[k]++;
                        if (one_run[k] == DB + 1) begin
                            m_press[k] = 1'b1; m_level[k] = 1'b1;
                            hold_t[k] = 0; zero_run[k] = 0; one_run[k] = 0;
                        end
                    end else begin
                        one_run[k] = 0;
                    end
                end else if (syn[k]) begin
                    if (zero_run[k] > 0) begin
                        zero_run[k] = 0; hold_t[k] = 0;
                    end else begin
                        hold_t[k]++;
                        if (hold_t[k] >= HOLD && (hold_t[k] - HOLD) % REP == 0)
                            m_rep[k] = 1'b1;
                    end
                end else begin
                    zero_run[k]++;
                    if (zero_run[k] == DB + 1) begin
                        m_rel[k] = 1'b1; m_level[k] = 1'b0;
                        zero_run[k] = 0; one_run[k] = 0;
                    end
                end
            end
        end
        m_nav = m_rel | m_rep;
        m_any = |(m_press | m_rel);
    endtask

    task automatic step();
        @(posedge clk_50M);
        cyc++;
        model_edge();
        #1;
        chk("key_level", key_level, m_level);
        chk("press_pulse", press_pulse, m_press);
        chk("release_pulse", release_pulse, m_rel);
        chk("repeat_pulse", repeat_pulse, m_rep);
        chk("nav_pulse", nav_pulse, m_nav);
        chk("any_event", {{(NK-1){1'b0}}, any_event}, {{(NK-1){1'b0}}, m_any});
        for (int k = 0; k < NK; k++) begin
            d_press[k] += int'(press_pulse[k]);
            d_rel[k]   += int'(release_pulse[k]);
            d_rep[k]   += int'(repeat_pulse[k]);
            d_nav[k]   += int'(nav_pulse[k]);
        end
        d_any += int'(any_event);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        clr_counts();
        rst_n = 1'b0;
        key_in = '1;
        run(3);
        chk("reset_level", key_level, '0);
        rst_n = 1'b1;
        run(5);

        // clean press on left
        clr_counts();
        key_in[KEY_LEFT] = 1'b0;
        run(30);
        key_in[KEY_LEFT] = 1'b1;
        run(20);
        chk_cnt("clean_press_cnt", d_press[KEY_LEFT], 1);
        chk_cnt("clean_release_cnt", d_rel[KEY_LEFT], 1);
        chk_cnt("clean_repeat_cnt", d_rep[KEY_LEFT], 0);

        // bouncing confirm key
        clr_counts();
        for (int i = 0; i < 10; i++) begin
            key_in[KEY_CONFIRM] = ~key_in[KEY_CONFIRM];
            run(3);
        end
        run(20);
        chk_cnt("bounce_press_cnt", d_press[KEY_CONFIRM], 0);
        chk_cnt("bounce_any_cnt", d_any, 0);
        clr_counts();
        key_in[KEY_CONFIRM] = 1'b0;
        run(30);
        chk_cnt("bounce_settle_press_cnt", d_press[KEY_CONFIRM], 1);
        key_in[KEY_CONFIRM] = 1'b1;
        run(20);

        // hold-to-repeat on up
        clr_counts();
        key_in[KEY_UP] = 1'b0;
        run(100);
        key_in[KEY_UP] = 1'b1;
        run(20);
        chk_cnt("hold_repeat_cnt", d_rep[KEY_UP], 6);
        chk_cnt("hold_nav_cnt", d_nav[KEY_UP], 7);
        chk_cnt("hold_release_cnt", d_rel[KEY_UP], 1);

        // simultaneous left + right
        clr_counts();
        key_in[KEY_LEFT] = 1'b0;
        key_in[KEY_RIGHT] = 1'b0;
        run(20);
        chk_cnt("simul_any_cycles", d_any, 1);
        chk_cnt("simul_press_right", d_press[KEY_RIGHT], 1);
        key_in[KEY_LEFT] = 1'b1;
        key_in[KEY_RIGHT] = 1'b1;
        run(20);

        // reset while down is held
        key_in[KEY_DOWN] = 1'b0;
        run(20);
        clr_counts();
        rst_n = 1'b0;
        run(1);
        chk("rst_mid_level", key_level, '0);
        rst_n = 1'b1;
        run(30);
        chk_cnt("rst_mid_release_cnt", d_rel[KEY_DOWN], 0);
        chk_cnt("rst_mid_press_cnt", d_press[KEY_DOWN], 1);
        key_in[KEY_DOWN] = 1'b1;
        run(20);

        // release bounce on quit
        key_in[KEY_QUIT] = 1'b0;
        run(15);
        clr_counts();
        key_in[KEY_QUIT] = 1'b1;
        run(4);
        key_in[KEY_QUIT] = 1'b0;
        run(30);
        chk_cnt("rel_bounce_release_cnt", d_rel[KEY_QUIT], 0);
        chk_cnt("rel_bounce_repeat_early", d_rep[KEY_QUIT], 0);
        run(30);
        key_in[KEY_QUIT] = 1'b1;
        run(20);

        // random activity with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(29, 0) == 0) key_in[k] = ~key_in[k];
            rst_n = ($urandom_range(599, 0) != 0);
            step();
        end
        rst_n = 1'b1;
        key_in = '1;
        run(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
